// File: rtl/dvp_pkg.sv
// Shared definitions for the video-to-AXI4-Stream output block:
// register map and input FSM encoding.
package dvp_pkg;

   localparam logic [5:0] REG_CTRL     = 6'h0;
   localparam logic [5:0] REG_STATUS   = 6'h1;
   localparam logic [5:0] REG_LINE_LEN = 6'h2;
   localparam logic [5:0] REG_DEST     = 6'h3;
   localparam logic [5:0] REG_FRM_CNT  = 6'h4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DROP   = 2'd2
   } in_state_t;

endpackage

// File: rtl/axis_vid_out_if.sv
// AXI4-Stream video output channel (pixel, frame/line markers, destination).
interface axis_vid_out_if #(
   parameter int DW = 16
) ();

   logic          tvalid;
   logic          tready;
   logic          tuser;
   logic          tlast;
   logic [DW-1:0] tdata;
   logic [3:0]    tdest;

   modport master (output tvalid, tuser, tlast, tdata, tdest, input tready);
   modport slave  (input tvalid, tuser, tlast, tdata, tdest, output tready);

endinterface

// File: rtl/vid_sfifo.sv
// Synchronous first-word-fall-through FIFO. The output register is part of
// the capacity, so cnt and full account for the entry presented on dout.
module vid_sfifo #(
   parameter int AW = 9,
   parameter int W  = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] dout,
   output logic         dout_vld,
   output logic         full,
   output logic [AW:0]  cnt
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   mem_cnt;
   logic          wr, ld, pop;

   assign pop  = rd_en & dout_vld;
   assign ld   = (mem_cnt != '0) & (~dout_vld | pop);
   assign cnt  = mem_cnt + {{AW{1'b0}}, dout_vld};
   assign full = (cnt == FULL_CNT);
   assign wr   = wr_en & ~full;

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= wr_data;
   end

   // Output register refills from the array in the same cycle it is popped,
   // which is what sustains one beat per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         mem_cnt  <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (ld) begin
            rptr     <= rptr + AW'(1);
            dout     <= mem[rptr];
            dout_vld <= 1'b1;
         end else if (pop) begin
            dout_vld <= 1'b0;
         end
         mem_cnt <= mem_cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, ld};
      end
   end

   a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= FULL_CNT);
   a_hold:      assert property (@(posedge clk) disable iff (!rst_n)
                   (dout_vld && !rd_en) |=> (dout_vld && $stable(dout)));

endmodule

// File: rtl/axis_vid_out.sv
// Parallel video (sof/vin/din) to AXI4-Stream bridge with frame sync,
// line-length driven tlast, overflow recovery and a small register bank.
module axis_vid_out
   import dvp_pkg::*;
#(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ibus_cs,
   input  logic          ibus_wr,
   input  logic [7:0]    ibus_addr,
   input  logic [31:0]   ibus_wrdata,
   output logic [31:0]   ibus_rddata,
   input  logic          sof_in,
   input  logic          vin,
   input  logic [DW-1:0] din,
   axis_vid_out_if.master axis
);

   logic [1:0]  rst_sync;
   logic        rst_i_n;
   logic        enb, ovf, ovf_set, ovf_clr;
   logic [15:0] line_len, col, col_pos, last_col;
   logic [3:0]  dest;
   logic [31:0] frm_cnt;
   logic        reg_wr, px_wr, px_last;
   logic [5:0]  reg_sel;
   logic        fifo_full;
   logic [AW:0] fifo_cnt;
   logic [DW+1:0] fifo_dout;
   logic        unused_ok;
   in_state_t   state, state_nxt;

   // Reset asserts immediately, releases two clocks after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_i_n = rst_sync[1];

   assign reg_sel   = ibus_addr[7:2];
   assign reg_wr    = ibus_cs & ibus_wr;
   assign ovf_clr   = reg_wr && (reg_sel == REG_STATUS) && ibus_wrdata[0];
   assign unused_ok = ^{ibus_addr[1:0], ibus_wrdata[31:16]};

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         enb      <= 1'b0;
         ovf      <= 1'b0;
         line_len <= '0;
         dest     <= '0;
         frm_cnt  <= '0;
      end else begin
         if (reg_wr && reg_sel == REG_CTRL)     enb      <= ibus_wrdata[0];
         if (reg_wr && reg_sel == REG_LINE_LEN) line_len <= ibus_wrdata[15:0];
         if (reg_wr && reg_sel == REG_DEST)     dest     <= ibus_wrdata[3:0];
         ovf <= ovf_set | (ovf & ~ovf_clr);
         if (px_wr && sof_in) frm_cnt <= frm_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enb) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DROP: if (vin && sof_in && !fifo_full) state_nxt = ST_ACTIVE;
            ST_ACTIVE:        if (vin && fifo_full)            state_nxt = ST_DROP;
            default:          state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outside ACTIVE only a start-of-frame pixel with room can be accepted.
   always_comb begin
      px_wr   = 1'b0;
      ovf_set = 1'b0;
      if (enb) begin
         case (state)
            ST_IDLE, ST_DROP: px_wr = vin & sof_in & ~fifo_full;
            ST_ACTIVE: begin
               px_wr   = vin & ~fifo_full;
               ovf_set = vin & fifo_full;
            end
            default: ;
         endcase
      end
   end

   // line_len of 0 wraps last_col to 0xFFFF, i.e. a 65536-pixel line.
   assign col_pos  = sof_in ? 16'd0 : col;
   assign last_col = line_len - 16'd1;
   assign px_last  = (col_pos == last_col);

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n)   col <= '0;
      else if (!enb)  col <= '0;
      else if (px_wr) col <= px_last ? 16'd0 : col_pos + 16'd1;
   end

   vid_sfifo #(.AW(AW), .W(DW + 2)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_i_n),
      .wr_en    (px_wr),
      .wr_data  ({sof_in, px_last, din}),
      .rd_en    (axis.tready),
      .dout     (fifo_dout),
      .dout_vld (axis.tvalid),
      .full     (fifo_full),
      .cnt      (fifo_cnt)
   );

   assign axis.tuser = fifo_dout[DW+1];
   assign axis.tlast = fifo_dout[DW];
   assign axis.tdata = fifo_dout[DW-1:0];
   assign axis.tdest = dest;

   always_comb begin
      ibus_rddata = '0;
      if (ibus_cs) begin
         case (reg_sel)
            REG_CTRL:     ibus_rddata[0] = enb;
            REG_STATUS: begin
               ibus_rddata[0]       = ovf;
               ibus_rddata[AW+16:16] = fifo_cnt;
            end
            REG_LINE_LEN: ibus_rddata[15:0] = line_len;
            REG_DEST:     ibus_rddata[3:0]  = dest;
            REG_FRM_CNT:  ibus_rddata       = frm_cnt;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_vid_out.sv
// Directed bench for axis_vid_out: framing, backpressure, overflow/DROP,
// late enable, mid-frame reset and a full 65536-pixel line.
module tb_axis_vid_out;

   localparam int AW = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          ibus_cs = 1'b0, ibus_wr = 1'b0;
   logic [7:0]    ibus_addr = '0;
   logic [31:0]   ibus_wrdata = '0;
   logic [31:0]   ibus_rddata;
   logic          sof_in = 1'b0, vin = 1'b0;
   logic [DW-1:0] din = '0;
   logic          tog = 1'b0;

   int tests = 0;
   int fails = 0;
   int stall_viol = 0;

   logic [DW+1:0] beats[$];
   logic          prev_stall = 1'b0;
   logic [DW+1:0] prev_beat = '0;

   always #5 clk = ~clk;

   axis_vid_out_if #(.DW(DW)) axis_if ();

   axis_vid_out #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ibus_cs     (ibus_cs),
      .ibus_wr     (ibus_wr),
      .ibus_addr   (ibus_addr),
      .ibus_wrdata (ibus_wrdata),
      .ibus_rddata (ibus_rddata),
      .sof_in      (sof_in),
      .vin         (vin),
      .din         (din),
      .axis        (axis_if)
   );

   // Beat capture and stall-stability watch, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!axis_if.tvalid ||
             {axis_if.tuser, axis_if.tlast, axis_if.tdata} !== prev_beat))
            stall_viol++;
         prev_stall = axis_if.tvalid & ~axis_if.tready;
         prev_beat  = {axis_if.tuser, axis_if.tlast, axis_if.tdata};
         if (axis_if.tvalid && axis_if.tready)
            beats.push_back({axis_if.tuser, axis_if.tlast, axis_if.tdata});
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (tog) axis_if.tready = ~axis_if.tready;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      ibus_cs = 1'b1; ibus_wr = 1'b1; ibus_addr = a; ibus_wrdata = d;
      tick();
      ibus_cs = 1'b0; ibus_wr = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      ibus_cs = 1'b1; ibus_wr = 1'b0; ibus_addr = a;
      #1;
      d = ibus_rddata;
      ibus_cs = 1'b0;
   endtask

   task automatic send(input int n, input logic [15:0] base, input logic sof_first);
      for (int i = 0; i < n; i++) begin
         vin = 1'b1; sof_in = sof_first && (i == 0); din = base + 16'(i);
         tick();
      end
      vin = 1'b0; sof_in = 1'b0;
   endtask

   // Expected frame: tuser on pixel 0, tlast every len-th pixel.
   task automatic chk_frame(input string tag, input int start, input int n,
                            input logic [15:0] base, input int len);
      logic [DW+1:0] e;
      for (int i = 0; i < n; i++) begin
         e = {1'(i == 0), 1'((i % len) == (len - 1)), base + 16'(i)};
         chk(tag, beats[start + i], e);
      end
   endtask

   initial begin
      logic [31:0] d;
      int nl, li;
      axis_if.tready = 1'b1;

      // reset state
      #2 rst_n = 1'b0;
      #10;
      chk("rst_tvalid", axis_if.tvalid, 0);
      chk("rst_tuser",  axis_if.tuser, 0);
      chk("rst_tlast",  axis_if.tlast, 0);
      chk("rst_tdata",  axis_if.tdata, 0);
      rd(8'h04, d); chk("rst_status", d, 0);
      rd(8'h10, d); chk("rst_frm", d, 0);
      tick(); rst_n = 1'b1;
      ticks(3);

      // two 4x2 frames, tready=1
      wr(8'h08, 32'd4); wr(8'h0C, 32'd5); wr(8'h00, 32'd1);
      chk("tdest", axis_if.tdest, 5);
      rd(8'h00, d); chk("ctrl_rd", d, 1);
      rd(8'h08, d); chk("line_len_rd", d, 4);
      rd(8'h40, d); chk("unmapped_rd", d, 0);
      beats.delete();
      send(8, 16'h100, 1'b1);
      send(8, 16'h200, 1'b1);
      ticks(6);
      chk("a_beats", beats.size(), 16);
      chk_frame("a_f0", 0, 8, 16'h100, 4);
      chk_frame("a_f1", 8, 8, 16'h200, 4);
      rd(8'h10, d); chk("a_frm", d, 2);
      rd(8'h04, d); chk("a_status", d, 0);
      ibus_addr = 8'h10; ibus_cs = 1'b0; #1;
      chk("cs0_rd", ibus_rddata, 0);

      // first-pixel latency
      beats.delete();
      vin = 1'b1; sof_in = 1'b1; din = 16'hABCD;
      tick();
      vin = 1'b0; sof_in = 1'b0;
      @(negedge clk); chk("lat_n1_tvalid", axis_if.tvalid, 0);
      tick();
      @(negedge clk);
      chk("lat_n2_tvalid", axis_if.tvalid, 1);
      chk("lat_n2_beat", {axis_if.tuser, axis_if.tlast, axis_if.tdata}, {2'b10, 16'hABCD});
      ticks(3);
      chk("lat_beats", beats.size(), 1);

      // same frames with tready toggling every cycle
      beats.delete();
      tog = 1'b1;
      send(8, 16'h100, 1'b1);
      send(8, 16'h200, 1'b1);
      ticks(30);
      tog = 1'b0; axis_if.tready = 1'b1;
      ticks(2);
      chk("b_beats", beats.size(), 16);
      chk_frame("b_f0", 0, 8, 16'h100, 4);
      chk_frame("b_f1", 8, 8, 16'h200, 4);
      chk("b_stall_stable", stall_viol, 0);
      rd(8'h04, d); chk("b_status", d, 0);

      // overflow: 20 pixels into 16 entries with tready=0
      axis_if.tready = 1'b0;
      beats.delete();
      send(20, 16'h300, 1'b1);
      ticks(3);
      rd(8'h04, d); chk("c_status_full", d, 32'h0010_0001);
      chk("c_held_beat", {axis_if.tvalid, axis_if.tuser, axis_if.tdata}, {2'b11, 16'h300});
      chk("c_no_beats", beats.size(), 0);
      axis_if.tready = 1'b1;
      ticks(20);
      chk("c_drain_beats", beats.size(), 16);
      chk_frame("c_drain", 0, 16, 16'h300, 4);
      rd(8'h04, d); chk("c_ovf_sticky", d, 1);
      send(1, 16'h3AA, 1'b0);
      ticks(4);
      chk("c_drop_nosof", beats.size(), 16);
      send(4, 16'h400, 1'b1);
      ticks(5);
      chk("c_resume_beats", beats.size(), 20);
      chk_frame("c_resume", 16, 4, 16'h400, 4);
      wr(8'h04, 32'd1);
      rd(8'h04, d); chk("c_ovf_clr", d, 0);
      rd(8'h10, d); chk("c_frm", d, 7);

      // enable mid-frame, no sof yet
      wr(8'h00, 32'd0);
      ticks(2);
      beats.delete();
      vin = 1'b1; sof_in = 1'b0; din = 16'h500;
      ticks(2);
      wr(8'h00, 32'd1);
      ticks(4);
      vin = 1'b0;
      ticks(3);
      rd(8'h04, d); chk("d_status", d, 0);
      chk("d_no_beats", beats.size(), 0);
      send(4, 16'h510, 1'b1);
      ticks(5);
      chk("d_beats", beats.size(), 4);
      chk_frame("d_frame", 0, 4, 16'h510, 4);

      // reset with 5 entries queued
      axis_if.tready = 1'b0;
      beats.delete();
      send(5, 16'h600, 1'b1);
      ticks(3);
      rd(8'h04, d); chk("e_status_q5", d, 32'h0005_0000);
      rst_n = 1'b0;
      #1;
      chk("e_rst_tvalid", axis_if.tvalid, 0);
      chk("e_rst_tdata", axis_if.tdata, 0);
      rd(8'h04, d); chk("e_rst_status", d, 0);
      tick();
      rst_n = 1'b1;
      axis_if.tready = 1'b1;
      ticks(5);
      chk("e_no_beats", beats.size(), 0);
      rd(8'h10, d); chk("e_frm_cleared", d, 0);
      chk("e_tdest_cleared", axis_if.tdest, 0);
      wr(8'h08, 32'd4); wr(8'h00, 32'd1);
      send(4, 16'h700, 1'b1);
      ticks(5);
      chk("e_beats", beats.size(), 4);
      chk_frame("e_frame", 0, 4, 16'h700, 4);

      // line_len=0: one 65536-pixel line
      wr(8'h08, 32'd0);
      beats.delete();
      send(65536, 16'h0000, 1'b1);
      ticks(5);
      chk("f_beats", beats.size(), 65536);
      nl = 0; li = -1;
      foreach (beats[i]) if (beats[i][DW]) begin nl++; li = i; end
      chk("f_tlast_count", nl, 1);
      chk("f_tlast_idx", li, 65535);
      chk("f_first_beat", beats[0], {2'b10, 16'h0000});
      rd(8'h10, d); chk("f_frm", d, 2);
      chk("stall_stable_all", stall_viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
